// File: rtl/regfile_pkg.sv
// Shared types and sizing helpers for the integer register file with scoreboard.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  function automatic int addr_width(input int nregs);
    return (nregs <= 2) ? 1 : $clog2(nregs);
  endfunction

  typedef logic [XLEN_DEF-1:0]                xword_t;
  typedef logic [addr_width(NREGS_DEF)-1:0]   regaddr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set by an issuing producer, cleared by the writeback.
module regfile_scoreboard #(
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sb_set_i,
  input  logic [AW-1:0]    sb_addr_i,
  input  logic [NREGS-1:0] clr_vec_i,
  output logic [NREGS-1:0] busy_vec_o
);

  logic [NREGS-1:0] busy_q, busy_d, set_vec;

  // A new producer issued in the same cycle as an older writeback keeps the reg busy.
  always_comb begin
    set_vec = '0;
    if (sb_set_i) set_vec[sb_addr_i] = 1'b1;
    busy_d    = (busy_q & ~clr_vec_i) | set_vec;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_vec_o = busy_q;

endmodule

// File: rtl/regfile_scb.sv
// Multi-port RISC-V integer register file with hardwired x0, optional forwarding,
// optional registered reads and a busy scoreboard.
module regfile_scb
  import regfile_pkg::*;
#(
  parameter int  XLEN    = XLEN_DEF,
  parameter int  NREGS   = NREGS_DEF,
  parameter int  NRP     = 2,
  parameter int  NWP     = 1,
  parameter int  BYPASS  = 1,
  parameter int  SYNC_RD = 0,
  localparam int AW      = addr_width(NREGS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NWP-1:0]            we_i,
  input  logic [NWP-1:0][AW-1:0]    waddr_i,
  input  logic [NWP-1:0][XLEN-1:0]  wdata_i,
  input  logic [NRP-1:0]            re_i,
  input  logic [NRP-1:0][AW-1:0]    raddr_i,
  output logic [NRP-1:0][XLEN-1:0]  rdata_o,
  input  logic                      sb_set_i,
  input  logic [AW-1:0]             sb_addr_i,
  output logic [NRP-1:0]            busy_o,
  output logic [NREGS-1:0]          busy_vec_o
);

  if (NRP < 1 || NRP > 4 || NWP < 1 || NWP > 2 || (NREGS != 16 && NREGS != 32)) begin : gen_bad_cfg
    $error("regfile_scb: unsupported NRP/NWP/NREGS configuration");
  end

  logic [XLEN-1:0]  mem_q [NREGS];
  logic [NWP-1:0]   wr_en;
  logic [NREGS-1:0] clr_vec;

  // Writes to x0 and anything presented while in reset never take effect.
  always_comb begin
    clr_vec = '0;
    for (int p = 0; p < NWP; p++) begin
      wr_en[p] = rst_n & we_i[p] & (waddr_i[p] != '0);
      if (wr_en[p]) clr_vec[waddr_i[p]] = 1'b1;
    end
  end

  // Ascending port order: on a same-address collision the highest port lands last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) mem_q[r] <= '0;
    end else begin
      for (int p = 0; p < NWP; p++)
        if (wr_en[p]) mem_q[waddr_i[p]] <= wdata_i[p];
    end
  end

  regfile_scoreboard #(.NREGS(NREGS), .AW(AW)) u_scb (
    .clk        (clk),
    .rst_n      (rst_n),
    .sb_set_i   (sb_set_i),
    .sb_addr_i  (sb_addr_i),
    .clr_vec_i  (clr_vec),
    .busy_vec_o (busy_vec_o)
  );

  for (genvar i = 0; i < NRP; i++) begin : gen_rd
    logic [XLEN-1:0] pre_val, fwd_val, sel_val;
    logic            hit;

    always_comb begin
      pre_val = mem_q[raddr_i[i]];
      fwd_val = pre_val;
      hit     = 1'b0;
      for (int p = 0; p < NWP; p++) begin
        if (wr_en[p] && waddr_i[p] == raddr_i[i]) begin
          hit     = 1'b1;
          fwd_val = wdata_i[p];
        end
      end
      sel_val = (BYPASS != 0) ? fwd_val : pre_val;
    end

    // A value being written this cycle is already available, so it is not busy.
    assign busy_o[i] = busy_vec_o[raddr_i[i]] & ~((BYPASS != 0) & hit);

    if (SYNC_RD != 0) begin : gen_sync
      logic [XLEN-1:0] rdata_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       rdata_q <= '0;
        else if (re_i[i]) rdata_q <= sel_val;
      end
      assign rdata_o[i] = rdata_q;
    end else begin : gen_comb
      logic unused_re;
      assign unused_re  = re_i[i];
      assign rdata_o[i] = rst_n ? sel_val : '0;
    end
  end

endmodule
